// File: rtl/breakout_frame_scheduler.sv
// breakout_frame_scheduler
//   Builds status frames for the breakout-to-host serializer. The raw port,
//   button and link-power lines are synchronized, the buttons are debounced,
//   and a frame goes out when the sampled state changes, when the keepalive
//   interval runs out, or unconditionally after reset. One frame at a time
//   is offered over a valid/ready handshake. After each accepted frame there
//   is a minimum gap before the next one can start.
//
// Ports
//   i_clk           system clock, sole domain
//   i_reset         synchronous, active-high reset
//   i_port[7:0]     raw port-presence lines (asynchronous)
//   i_button[7:0]   raw button lines (asynchronous, bouncy)
//   i_link_pow[3:0] raw link-power lines (asynchronous)
//   i_ser_ready     serializer can take a frame
//   o_frame_valid   o_frame holds a frame being offered
//   o_frame[23:0]   {seq[3:0], link_pow[3:0], button[7:0], port[7:0]}
//   o_keepalive     current frame was sent only because keepalive expired
//   o_coalesce_cnt  (SCHED_STATS_EN only) count of snapshot changes seen
//                   while a frame was in flight or in the gap, saturating
//
// Optional feature macro: SCHED_STATS_EN

// One debounce lane: the output follows the input only after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module breakout_frame_scheduler_db #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt   <= '0;
      o_deb <= 1'b0;
    end else if (i_raw != o_deb) begin
      if (cnt == CNT_LAST) begin
        o_deb <= i_raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      // any agreeing sample restarts the count
      cnt <= '0;
    end
  end
endmodule

module breakout_frame_scheduler #(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int KEEPALIVE_CYCLES = 50000,
  parameter int MIN_GAP_CYCLES   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_port,
  input  logic [7:0]  i_button,
  input  logic [3:0]  i_link_pow,
  input  logic        i_ser_ready,
  output logic        o_frame_valid,
  output logic [23:0] o_frame,
  output logic        o_keepalive
`ifdef SCHED_STATS_EN
  , output logic [15:0] o_coalesce_cnt
`endif
);
  localparam int NUM_BTN = 8;
  localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);
  localparam int GW = (MIN_GAP_CYCLES < 1) ? 1 : $clog2(MIN_GAP_CYCLES + 1);
  localparam logic [KW-1:0] KA_LAST  = KW'(KEEPALIVE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP_CYCLES - 1);

  typedef struct packed {
    logic [3:0] link_pow;
    logic [7:0] button;
    logic [7:0] port;
  } snap_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // two-flop synchronizer on all 20 raw lines
  snap_t sync1, sync2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= snap_t'({i_link_pow, i_button, i_port});
      sync2 <= sync1;
    end
  end

  // per-button debounce lanes
  logic [NUM_BTN-1:0] btn_sync;
  logic [NUM_BTN-1:0] btn_deb;

  assign btn_sync = sync2.button;

  breakout_frame_scheduler_db #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db [NUM_BTN-1:0] (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_raw  (btn_sync),
    .o_deb  (btn_deb)
  );

  snap_t snap;
  always_comb begin
    snap          = sync2;
    snap.button   = btn_deb;
  end

  state_t          state;
  snap_t           last_sent;
  logic [3:0]      seq;
  logic            force_q;
  logic            ka_expired;
  logic [KW-1:0]   ka_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            pending;

  // A change that reverts before IDLE samples it never shows up here, so it
  // costs no frame.
  assign pending = (snap != last_sent) | force_q | ka_expired;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      o_frame_valid <= 1'b0;
      o_frame       <= '0;
      o_keepalive   <= 1'b0;
      last_sent     <= '0;
      seq           <= 4'd0;
      force_q       <= 1'b1;
      ka_expired    <= 1'b0;
      ka_cnt        <= '0;
      gap_cnt       <= '0;
    end else begin
      // keepalive only ages while nothing is in flight; it holds at the last
      // count once expired and is cleared by the next acceptance
      if (state != SEND) begin
        if (ka_cnt == KA_LAST) ka_expired <= 1'b1;
        else                   ka_cnt     <= ka_cnt + KW'(1);
      end

      unique case (state)
        IDLE: begin
          if (pending) begin
            o_frame       <= {seq, snap};
            // a state change always wins over a concurrent keepalive expiry
            o_keepalive   <= (snap == last_sent) & ~force_q;
            o_frame_valid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          // o_frame is frozen here; input movement is picked up after GAP
          if (o_frame_valid && i_ser_ready) begin
            o_frame_valid <= 1'b0;
            last_sent     <= snap_t'(o_frame[19:0]);
            seq           <= seq + 4'd1;
            force_q       <= 1'b0;
            ka_expired    <= 1'b0;
            ka_cnt        <= '0;
            gap_cnt       <= '0;
            state         <= (MIN_GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state   <= IDLE;
          else                     gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  // counts snapshot movement that happens while the scheduler is busy and
  // therefore gets folded into a later frame
  snap_t snap_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      snap_d         <= '0;
      o_coalesce_cnt <= 16'd0;
    end else begin
      snap_d <= snap;
      if ((state == SEND || state == GAP) && snap != snap_d &&
          o_coalesce_cnt != 16'hFFFF)
        o_coalesce_cnt <= o_coalesce_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_breakout_frame_scheduler.sv
module tb_breakout_frame_scheduler;
  localparam int D  = 8;
  localparam int KA = 100;
  localparam int G  = 6;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_port = '0;
  logic [7:0]  i_button = '0;
  logic [3:0]  i_link_pow = '0;
  logic        i_ser_ready = 1'b1;
  logic        o_frame_valid;
  logic [23:0] o_frame;
  logic        o_keepalive;
`ifdef SCHED_STATS_EN
  logic [15:0] o_coalesce_cnt;
`endif

  breakout_frame_scheduler #(
    .DEBOUNCE_CYCLES(D), .KEEPALIVE_CYCLES(KA), .MIN_GAP_CYCLES(G)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_port(i_port), .i_button(i_button),
    .i_link_pow(i_link_pow), .i_ser_ready(i_ser_ready),
    .o_frame_valid(o_frame_valid), .o_frame(o_frame), .o_keepalive(o_keepalive)
`ifdef SCHED_STATS_EN
    , .o_coalesce_cnt(o_coalesce_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timing is tracked by edge number: the gap ends at an absolute edge and
  // keepalive expiry is "KA non-busy edges since the last acceptance".
  logic [19:0] m_s1, m_s2;
  logic [7:0]  m_deb;
  int          m_run [8];
  logic [19:0] m_last;
  logic [3:0]  m_seq;
  bit          m_force;
  int          m_nonsend;
  bit          m_insend;
  longint      m_edge = 0;
  longint      m_gap_end = 0;
  logic        m_valid;
  logic [23:0] m_frame;
  logic        m_ka;
  logic [19:0] m_snap_prev;
  int          m_coal;

  task automatic model_step();
    logic [19:0] snap;
    bit idle, expd;
    if (i_reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      foreach (m_run[b]) m_run[b] = 0;
      m_last = '0; m_seq = '0; m_force = 1; m_nonsend = 0; m_insend = 0;
      m_gap_end = m_edge; m_valid = 0; m_frame = '0; m_ka = 0;
      m_snap_prev = '0; m_coal = 0;
    end else begin
      snap = {m_s2[19:16], m_deb, m_s2[7:0]};
      idle = !m_insend && (m_edge > m_gap_end);
      expd = (m_nonsend >= KA);
      if (!idle && snap != m_snap_prev && m_coal < 65535) m_coal++;
      if (!m_insend) m_nonsend++;
      if (idle && (snap != m_last || m_force || expd)) begin
        m_frame = {m_seq, snap};
        m_ka = (snap == m_last) && !m_force;
        m_valid = 1; m_insend = 1;
      end else if (m_insend && i_ser_ready) begin
        m_valid = 0; m_last = m_frame[19:0]; m_seq = m_seq + 4'd1;
        m_force = 0; m_nonsend = 0; m_gap_end = m_edge + G; m_insend = 0;
      end
      for (int b = 0; b < 8; b++) begin
        if (m_s2[8+b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin m_deb[b] = m_s2[8+b]; m_run[b] = 0; end
        end else m_run[b] = 0;
      end
      m_snap_prev = snap;
      m_s2 = m_s1;
      m_s1 = {i_link_pow, i_button, i_port};
    end
    m_edge++;
  endtask

  initial forever begin
    @(posedge i_clk);
    model_step();
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      chk("valid", {31'd0, o_frame_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("frame", {8'd0, o_frame}, {8'd0, m_frame});
        chk("keepalive", {31'd0, o_keepalive}, {31'd0, m_ka});
      end
`ifdef SCHED_STATS_EN
      chk("coalesce", {16'd0, o_coalesce_cnt}, m_coal);
`endif
    end
  end

  // wait (bounded) for o_frame_valid, returning edges elapsed
  task automatic wait_valid(input int limit, output int edges);
    edges = 0;
    do begin
      @(negedge i_clk);
      edges++;
    end while (!o_frame_valid && edges < limit);
    if (!o_frame_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] bounce [5];
  int e;
  logic [3:0] prev_seq;

  initial begin
    bounce[0] = 8'hAA; bounce[1] = 8'h00; bounce[2] = 8'hAA;
    bounce[3] = 8'h00; bounce[4] = 8'h00;

    // reset state
    repeat (3) @(negedge i_clk);
    chk_en = 1;
    chk("rst_valid", {31'd0, o_frame_valid}, 32'd0);
    chk("rst_frame", {8'd0, o_frame}, 32'd0);
    chk("rst_ka", {31'd0, o_keepalive}, 32'd0);
    i_reset = 0;

    // forced first frame
    wait_valid(10, e);
    chk("first_lat", e, 1);
    chk("first_frame", {8'd0, o_frame}, 32'h000000);
    chk("first_ka", {31'd0, o_keepalive}, 32'd0);
    @(negedge i_clk);
    chk("first_accept", {31'd0, o_frame_valid}, 32'd0);
    repeat (20) @(negedge i_clk);

    // port/link change: 3-edge latency
    i_port = 8'hF0; i_link_pow = 4'h8;
    wait_valid(50, e);
    chk("port_lat", e, 3);
    chk("port_frame", {8'd0, o_frame}, 32'h1800F0);
    chk("port_ka", {31'd0, o_keepalive}, 32'd0);
    @(negedge i_clk);
    repeat (20) @(negedge i_clk);

    // bouncing buttons then settle
    for (int k = 0; k < 5; k++) begin
      i_button = bounce[k];
      @(negedge i_clk);
      chk("bounce_quiet", {31'd0, o_frame_valid}, 32'd0);
    end
    i_button = 8'hAA;
    wait_valid(100, e);
    chk("btn_lat", e, 3 + D);
    chk("btn_frame", {8'd0, o_frame}, 32'h28AAF0);
    @(negedge i_clk);
    repeat (20) @(negedge i_clk);

    // stall with link_pow moving underneath
    i_ser_ready = 0;
    i_port = 8'h0F;
    wait_valid(50, e);
    chk("stall_lat", e, 3);
    i_link_pow = 4'hF;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      chk("stall_hold", {8'd0, o_frame}, 32'h38AA0F);
    end
    i_ser_ready = 1;
    @(negedge i_clk);
    chk("stall_accept", {31'd0, o_frame_valid}, 32'd0);
    wait_valid(50, e);
    chk("post_stall_lat", e, G + 1);
    chk("post_stall_frame", {8'd0, o_frame}, 32'h4FAA0F);
    chk("post_stall_ka", {31'd0, o_keepalive}, 32'd0);
`ifdef SCHED_STATS_EN
    chk("coalesce_one", {16'd0, o_coalesce_cnt}, 32'd1);
`endif

    // keepalive frames and seq wrap
    prev_seq = 4'd4;
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clk);
      wait_valid(300, e);
      chk("ka_interval", e, KA + 1);
      chk("ka_flag", {31'd0, o_keepalive}, 32'd1);
      chk("ka_seq", {28'd0, o_frame[23:20]}, {28'd0, 4'(prev_seq + 4'd1)});
      prev_seq = o_frame[23:20];
    end

    // reset while a frame is offered
    i_ser_ready = 0;
    @(negedge i_clk);
    chk("pre_rst_valid", {31'd0, o_frame_valid}, 32'd1);
    i_reset = 1;
    @(negedge i_clk);
    chk("mid_rst_valid", {31'd0, o_frame_valid}, 32'd0);
    i_reset = 0; i_ser_ready = 1;
    wait_valid(10, e);
    chk("post_rst_lat", e, 1);
    chk("post_rst_seq", {28'd0, o_frame[23:20]}, 32'd0);
    chk("post_rst_ka", {31'd0, o_keepalive}, 32'd0);

    // randomized traffic checked by the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge i_clk);
      i_reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 5) == 0) i_port = 8'($urandom);
      if ($urandom_range(0, 9) == 0) i_link_pow = 4'($urandom);
      if ($urandom_range(0, 7) == 0) i_button = 8'($urandom);
      i_ser_ready = ($urandom_range(0, 3) != 0);
    end
    i_reset = 0;
    repeat (10) @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
